// File: rtl/ps2_key_receiver_if.sv
// rtl/ps2_key_receiver_if.sv - PS/2 pin inputs and decoded key outputs of the keyboard receiver
interface ps2_key_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] o_scancode;
    logic       o_code_valid;
    logic       o_frame_err;
    logic       o_jump;
    logic       o_duck;

    // Keyboard side: drives the pins, observes the decoded outputs.
    modport master (
        output ps2_clk,
        output ps2_data,
        input  o_scancode,
        input  o_code_valid,
        input  o_frame_err,
        input  o_jump,
        input  o_duck
    );

    // Receiver side.
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output o_scancode,
        output o_code_valid,
        output o_frame_err,
        output o_jump,
        output o_duck
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard deframer and scan-code set 2 jump/duck decoder
module ps2_key_receiver #(
    parameter int         FILT_LEN    = 8,      // must be >= 2
    parameter int         TIMEOUT_CYC = 20000,
    parameter logic [7:0] JUMP_CODE   = 8'h29,
    parameter logic [7:0] DUCK_CODE   = 8'h1B
) (
    input  logic              i_clk,
    input  logic              rst_n,
    ps2_key_receiver_if.slave bus
);
    localparam int              FC_W    = $clog2(FILT_LEN);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] EXT_JUMP = 8'h75;
    localparam logic [7:0] EXT_DUCK = 8'h72;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic            clk_s1_q, clk_s2_q;
    logic            dat_s1_q, dat_s2_q;
    logic [FC_W-1:0] filt_cnt_q;
    logic            filt_clk_q;
    logic            filt_prev_q;

    state_t          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            ext_q;
    logic            brk_q;

    logic [7:0]      scancode_q;
    logic            code_valid_q;
    logic            frame_err_q;
    logic            jump_q;
    logic            duck_q;

    logic            strobe;
    logic            frame_ok_d;
    logic            is_jump_d;
    logic            is_duck_d;
    logic            wd_expired_d;

    assign strobe       = filt_prev_q & ~filt_clk_q;
    // Odd parity: data bits plus parity bit carry an odd number of ones.
    assign frame_ok_d   = dat_s2_q & (^{shift_q, parity_q});
    assign is_jump_d    = ext_q ? (shift_q == EXT_JUMP) : (shift_q == JUMP_CODE);
    assign is_duck_d    = ext_q ? (shift_q == EXT_DUCK) : (shift_q == DUCK_CODE);
    assign wd_expired_d = (state_q != S_IDLE) && (wd_cnt_q == WD_LAST);

    assign bus.o_scancode   = scancode_q;
    assign bus.o_code_valid = code_valid_q;
    assign bus.o_frame_err  = frame_err_q;
    assign bus.o_jump       = jump_q;
    assign bus.o_duck       = duck_q;

    // Two-flop synchronisers for both asynchronous pins; idle level is high.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= bus.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: the filtered clock follows only after FILT_LEN consecutive new-level samples.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_prev_q <= filt_clk_q;
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FC_LAST) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FC_W'(1);
            end
        end
    end

    // Frame FSM, watchdog and make/break decoder with registered outputs.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            wd_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            scancode_q   <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            jump_q       <= 1'b0;
            duck_q       <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (strobe) begin
                wd_cnt_q <= '0;
            end else if (state_q != S_IDLE) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end

            if (!strobe && wd_expired_d) begin
                // Keyboard stopped clocking mid-frame: drop the frame and any prefix.
                state_q     <= S_IDLE;
                wd_cnt_q    <= '0;
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
            end else if (strobe) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {dat_s2_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (frame_ok_d) begin
                            scancode_q   <= shift_q;
                            code_valid_q <= 1'b1;
                            if (shift_q == CODE_EXT) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == CODE_BRK) begin
                                brk_q <= 1'b1;
                            end else begin
                                if (is_jump_d) begin
                                    jump_q <= ~brk_q;
                                end
                                if (is_duck_d) begin
                                    duck_q <= ~brk_q;
                                end
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_q       <= 1'b0;
                            brk_q       <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule
